// File: rtl/spatial_encoder_if.sv
// Bus bundle for spatial_encoder: the per-channel (im, projm) input stream
// and the spatial HV output stream, each with valid/ready.
// Width comes from `HV_DIMENSION (defaulted here when not set by the build).

`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif

interface spatial_encoder_if #(
   parameter int dim = `HV_DIMENSION
);
   logic [dim-1:0] im;
   logic [dim-1:0] projm;
   logic           din_valid;
   logic           din_ready;
   logic [dim-1:0] hvout;
   logic           dout_valid;
   logic           dout_ready;

   // Producer of channel data and consumer of spatial HVs
   modport master (
      output im, projm, din_valid, dout_ready,
      input  din_ready, hvout, dout_valid
   );

   // The encoder itself
   modport slave (
      input  im, projm, din_valid, dout_ready,
      output din_ready, hvout, dout_valid
   );
endinterface

// File: rtl/spatial_encoder.sv
// spatial_encoder: binds each channel pair (im ^ projm) and bundles the
// num_channel bound HVs of one sample by per-dimension majority vote.
// Optional feature macro: SPATIAL_TIEBREAK_EN -- when defined, a tie
// (exactly half the votes, even num_channel) takes channel 0's bound bit;
// when undefined, ties resolve to 0 and no tie register exists.

`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif

module spatial_encoder #(
   parameter int num_channel = 32,
   parameter int cnt_width   = $clog2(num_channel + 1)
) (
   input logic              clk,
   input logic              rst,
   spatial_encoder_if.slave bus
);

   localparam int dim = `HV_DIMENSION;
   localparam logic [cnt_width-1:0] last_idx  = cnt_width'(num_channel - 1);
   // num_channel compared against twice the vote total avoids halving
   localparam logic [cnt_width:0]   threshold = (cnt_width + 1)'(num_channel);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 din_ready_r;
   logic                 dout_valid_r;
   logic [dim-1:0]       hvout_r;
   logic [cnt_width-1:0] chan_idx;
   logic [cnt_width-1:0] cnt   [dim];
   logic [cnt_width-1:0] total [dim];
   logic [dim-1:0]       bound;
   logic [dim-1:0]       maj;
   logic [dim-1:0]       tie_bit;
   logic                 accept;
   logic                 last;

   assign bus.din_ready  = din_ready_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.hvout      = hvout_r;

`ifdef SPATIAL_TIEBREAK_EN
   logic [dim-1:0] tie_reg;

   // Capture channel 0's bound HV as the tie-break reference of each sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tie_reg <= '0;
      end else if (accept && (chan_idx == '0)) begin
         tie_reg <= bound;
      end else begin
         tie_reg <= tie_reg;
      end
   end

   // Ties follow the captured channel 0 bit
   always_comb begin
      tie_bit = tie_reg;
   end
`else
   // Ties resolve to 0
   always_comb begin
      tie_bit = '0;
   end
`endif

   // Bind, handshake decode and next-state selection
   always_comb begin
      bound      = bus.im ^ bus.projm;
      accept     = bus.din_valid & din_ready_r;
      last       = accept && (chan_idx == last_idx);
      state_next = state;
      case (state)
         ACCUM: begin
            if (last) begin
               state_next = DONE;
            end else begin
               state_next = ACCUM;
            end
         end
         DONE: begin
            if (dout_valid_r && bus.dout_ready) begin
               state_next = ACCUM;
            end else begin
               state_next = DONE;
            end
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
   end

   // Per-dimension running total including the channel being accepted, and its majority
   always_comb begin
      for (int d = 0; d < dim; d++) begin
         total[d] = cnt[d] + cnt_width'(bound[d]);
         if ({total[d], 1'b0} > threshold) begin
            maj[d] = 1'b1;
         end else if ({total[d], 1'b0} == threshold) begin
            maj[d] = tie_bit[d];
         end else begin
            maj[d] = 1'b0;
         end
      end
   end

   // State register with registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ACCUM;
         din_ready_r  <= 1'b1;
         dout_valid_r <= 1'b0;
      end else begin
         state        <= state_next;
         din_ready_r  <= (state_next == ACCUM);
         dout_valid_r <= (state_next == DONE);
      end
   end

   // Vote counters, channel index and the held spatial HV
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chan_idx <= '0;
         hvout_r  <= '0;
         for (int d = 0; d < dim; d++) begin
            cnt[d] <= '0;
         end
      end else if (last) begin
         chan_idx <= '0;
         hvout_r  <= maj;
         for (int d = 0; d < dim; d++) begin
            cnt[d] <= '0;
         end
      end else if (accept) begin
         chan_idx <= chan_idx + cnt_width'(1);
         for (int d = 0; d < dim; d++) begin
            cnt[d] <= total[d];
         end
      end else begin
         chan_idx <= chan_idx;
      end
   end

endmodule

// File: tb/tb_spatial_encoder.sv
// Self-checking bench for spatial_encoder: directed scenarios plus
// randomized samples compared against a counting majority model.

`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif

module tb_spatial_encoder;

   localparam int dim    = `HV_DIMENSION;
   localparam int num_ch = 32;
   localparam int n_rand = 380;

   typedef logic [dim-1:0] hv_t;

   logic clk;
   logic rst;
   int   total_cnt;
   int   bad_cnt;
   hv_t  exp_q [$];

   spatial_encoder_if bus ();

   spatial_encoder #(.num_channel(num_ch)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input hv_t obs, input hv_t exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic hv_t rand_hv();
      hv_t r;
      for (int i = 0; i < dim; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   // Reference: count set bound bits per dimension and take the majority
   function automatic hv_t ref_model(input hv_t ims [num_ch], input hv_t pms [num_ch]);
      hv_t r;
      for (int d = 0; d < dim; d++) begin
         int ones = 0;
         for (int k = 0; k < num_ch; k++) ones += int'(ims[k][d] ^ pms[k][d]);
         if (2 * ones > num_ch) r[d] = 1'b1;
         else if (2 * ones < num_ch) r[d] = 1'b0;
`ifdef SPATIAL_TIEBREAK_EN
         else r[d] = ims[0][d] ^ pms[0][d];
`else
         else r[d] = 1'b0;
`endif
      end
      return r;
   endfunction

   // Present one pair at a negedge and return at the negedge after it was accepted
   task automatic send_pair(input hv_t a, input hv_t b, input int gap, output int waits);
      bit acc;
      waits = 0;
      acc   = 1'b0;
      for (int g = 0; g < gap; g++) begin
         bus.din_valid = 1'b0;
         @(negedge clk);
      end
      bus.im        = a;
      bus.projm     = b;
      bus.din_valid = 1'b1;
      for (int t = 0; t < 3000; t++) begin
         acc = bus.din_ready;
         @(negedge clk);
         if (acc) break;
         waits++;
      end
      if (!acc) chk("din_timeout", hv_t'(0), hv_t'(1));
   endtask

   task automatic send_sample(input hv_t ims [num_ch], input hv_t pms [num_ch],
                              input bit rnd, output int waits);
      int w;
      waits = 0;
      for (int k = 0; k < num_ch; k++) begin
         send_pair(ims[k], pms[k],
                   (rnd && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 0, w);
         waits += w;
      end
   endtask

   // Raise dout_ready after a gap, capture hvout and complete one handshake
   task automatic get_out(input int gap, output hv_t hv);
      bit ok;
      ok = 1'b0;
      hv = '0;
      bus.dout_ready = 1'b0;
      repeat (gap) @(negedge clk);
      bus.dout_ready = 1'b1;
      for (int t = 0; t < 20000; t++) begin
         if (bus.dout_valid) begin
            hv = bus.hvout;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      bus.dout_ready = 1'b0;
      if (!ok) chk("dout_timeout", hv_t'(0), hv_t'(1));
   endtask

   initial begin
      hv_t ims [num_ch];
      hv_t pms [num_ch];
      hv_t hv;
      hv_t exp;
      hv_t held;
      int  waits;

      total_cnt      = 0;
      bad_cnt        = 0;
      rst            = 1'b1;
      bus.im         = '0;
      bus.projm      = '0;
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dout_valid", hv_t'(bus.dout_valid), hv_t'(0));
      chk("rst_hvout", bus.hvout, hv_t'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("rst_din_ready", hv_t'(bus.din_ready), hv_t'(1));

      // 1: all-1 bound, din_valid held high, accepted back to back
      for (int k = 0; k < num_ch; k++) begin ims[k] = '1; pms[k] = '0; end
      send_sample(ims, pms, 1'b0, waits);
      chk("t1_no_stall", hv_t'(waits), hv_t'(0));
      chk("t1_dout_valid", hv_t'(bus.dout_valid), hv_t'(1));
      chk("t1_din_ready_low", hv_t'(bus.din_ready), hv_t'(0));
      bus.din_valid = 1'b0;
      get_out(0, hv);
      chk("t1_hvout", hv, hv_t'('1));

      // 2: bit 0 set in channels 0-15 only, an exact tie
      for (int k = 0; k < num_ch; k++) begin
         ims[k] = '0;
         pms[k] = '0;
         ims[k][0] = (k < 16);
      end
      exp = ref_model(ims, pms);
      send_sample(ims, pms, 1'b0, waits);
      bus.din_valid = 1'b0;
      get_out(2, hv);
      chk("t2_hvout", hv, exp);
`ifdef SPATIAL_TIEBREAK_EN
      chk("t2_tie_bit0", hv_t'(hv[0]), hv_t'(1));
`else
      chk("t2_tie_bit0", hv_t'(hv[0]), hv_t'(0));
`endif

      // 3: bit 5 set via projm in 17 channels
      for (int k = 0; k < num_ch; k++) begin
         ims[k] = '0;
         pms[k] = '0;
         pms[k][5] = (k >= 15);
      end
      exp = ref_model(ims, pms);
      send_sample(ims, pms, 1'b0, waits);
      bus.din_valid = 1'b0;
      get_out(0, hv);
      chk("t3_hvout", hv, exp);
      chk("t3_bit5", hv_t'(hv[5]), hv_t'(1));

      // 4: output held under backpressure
      for (int k = 0; k < num_ch; k++) begin ims[k] = rand_hv(); pms[k] = rand_hv(); end
      exp = ref_model(ims, pms);
      send_sample(ims, pms, 1'b0, waits);
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         chk("t4_hold_valid", hv_t'(bus.dout_valid), hv_t'(1));
         chk("t4_hold_hvout", bus.hvout, exp);
         chk("t4_hold_din_ready", hv_t'(bus.din_ready), hv_t'(0));
         @(negedge clk);
      end
      bus.dout_ready = 1'b1;
      @(negedge clk);
      bus.dout_ready = 1'b0;
      chk("t4_din_ready_back", hv_t'(bus.din_ready), hv_t'(1));
      chk("t4_dout_valid_drop", hv_t'(bus.dout_valid), hv_t'(0));

      // 5: reset mid-sample and with a pending output
      for (int k = 0; k < 10; k++) send_pair('1, '0, 0, waits);
      bus.din_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("t5_rst_din_ready", hv_t'(bus.din_ready), hv_t'(1));
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < num_ch; k++) begin ims[k] = '0; pms[k] = '0; end
      send_sample(ims, pms, 1'b0, waits);
      bus.din_valid = 1'b0;
      get_out(1, hv);
      chk("t5_cleared", hv, hv_t'(0));
      for (int k = 0; k < num_ch; k++) begin ims[k] = '1; pms[k] = '0; end
      send_sample(ims, pms, 1'b0, waits);
      bus.din_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("t5_pending_dropped", hv_t'(bus.dout_valid), hv_t'(0));
      chk("t5_pending_hvout", bus.hvout, hv_t'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 6: randomized samples with random input and output gaps
      fork
         begin
            hv_t ri [num_ch];
            hv_t rp [num_ch];
            int  w;
            for (int s = 0; s < n_rand; s++) begin
               for (int k = 0; k < num_ch; k++) begin ri[k] = rand_hv(); rp[k] = rand_hv(); end
               exp_q.push_back(ref_model(ri, rp));
               send_sample(ri, rp, 1'b1, w);
            end
            bus.din_valid = 1'b0;
         end
         begin
            hv_t got;
            hv_t want;
            for (int s = 0; s < n_rand; s++) begin
               get_out(int'($urandom_range(0, 15)), got);
               if (exp_q.size() == 0) begin
                  chk("t6_queue_empty", hv_t'(0), hv_t'(1));
               end else begin
                  want = exp_q.pop_front();
                  chk("t6_sample", got, want);
               end
            end
         end
      join

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
